// File: rtl/bk_adder_pipe_if.sv
// Operand/result handshake bundle for bk_adder_pipe.
// master drives operands and out_ready; slave is the adder.
interface bk_adder_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, acc
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, acc
    );
endinterface

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready handshake and an
// accumulator whose read-after-write hazard is closed by stalling intake.
module bk_adder_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    bk_adder_pipe_if.slave bus
);
    localparam int unsigned LOG_W = $clog2(WIDTH);
    localparam int unsigned MSB   = WIDTH - 1;
    // Stage payload: {acc_op, x_msb, y_msb, cin, p0, g, p}
    localparam int unsigned PW    = 3 * WIDTH + 4;

    // In-place up-sweep; returns {g, p}. Bit 2^k-1 ends up holding prefix [2^k-1:0].
    function automatic logic [2*WIDTH-1:0] up_sweep(input logic [WIDTH-1:0] g_in,
                                                    input logic [WIDTH-1:0] p_in);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = g_in;
        p = p_in;
        for (int d = 0; d < int'(LOG_W); d++) begin
            for (int i = (2 << d) - 1; i < int'(WIDTH); i += (2 << d)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << d)]);
                p[i] = p[i] & p[i - (1 << d)];
            end
        end
        return {g, p};
    endfunction

    // Down-sweep fills the remaining positions from already-complete prefixes.
    function automatic logic [WIDTH-1:0] down_sweep(input logic [WIDTH-1:0] g_in,
                                                    input logic [WIDTH-1:0] p_in);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = g_in;
        p = p_in;
        for (int d = int'(LOG_W) - 2; d >= 0; d--) begin
            for (int i = (3 << d) - 1; i < int'(WIDTH); i += (2 << d)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << d)]);
                p[i] = p[i] & p[i - (1 << d)];
            end
        end
        return g;
    endfunction

    logic             stall_c, in_ready_c, accept_c, retire_c;
    logic             out_valid_q, cout_q, ovf_q, acc_op_q, busy_q;
    logic [WIDTH-1:0] sum_q, acc_q;

    assign stall_c    = out_valid_q && !bus.out_ready;
    assign in_ready_c = !stall_c && !busy_q;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign retire_c   = out_valid_q && bus.out_ready;

    // Operand mux and generate/propagate; cin is folded into bit 0's generate.
    logic [WIDTH-1:0] x_c, y_c, g0_c, p0_c;
    logic             c_c;
    always_comb begin
        x_c = bus.a;
        y_c = bus.b;
        c_c = bus.cin;
        case (bus.op)
            2'b01: begin y_c = ~bus.b; c_c = 1'b1; end
            2'b10: begin x_c = acc_q;  y_c = bus.a; end
            2'b11: begin y_c = '0;     c_c = 1'b0; end
            default: ;
        endcase
        g0_c    = x_c & y_c;
        p0_c    = x_c ^ y_c;
        g0_c[0] = g0_c[0] | (p0_c[0] & c_c);
    end

    logic [PW-1:0] b0_c, b1, b1u_c, b2;
    logic          v1, v2;
    assign b0_c = {bus.op[1], x_c[MSB], y_c[MSB], c_c, p0_c, g0_c, p0_c};

    if (STAGES >= 2) begin : g_cut1
        logic          v_q;
        logic [PW-1:0] b_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                b_q <= '0;
            end else if (!stall_c) begin
                v_q <= accept_c;
                b_q <= b0_c;
            end
        end
        assign v1 = v_q;
        assign b1 = b_q;
    end else begin : g_pass1
        assign v1 = accept_c;
        assign b1 = b0_c;
    end

    assign b1u_c = {b1[PW-1:2*WIDTH], up_sweep(b1[2*WIDTH-1:WIDTH], b1[WIDTH-1:0])};

    if (STAGES >= 3) begin : g_cut2
        logic          v_q;
        logic [PW-1:0] b_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                b_q <= '0;
            end else if (!stall_c) begin
                v_q <= v1;
                b_q <= b1u_c;
            end
        end
        assign v2 = v_q;
        assign b2 = b_q;
    end else begin : g_pass2
        assign v2 = v1;
        assign b2 = b1u_c;
    end

    // Carry into bit i is the full prefix generate of bits [i-1:0].
    logic [WIDTH-1:0] carry_c, sum_c;
    logic             cout_c, ovf_c;
    assign carry_c = down_sweep(b2[2*WIDTH-1:WIDTH], b2[WIDTH-1:0]);
    assign sum_c   = b2[3*WIDTH-1:2*WIDTH] ^ {carry_c[MSB-1:0], b2[PW-4]};
    assign cout_c  = carry_c[MSB];
    assign ovf_c   = (b2[PW-2] == b2[PW-3]) && (sum_c[MSB] != b2[PW-2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_op_q    <= 1'b0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (!stall_c) begin
                out_valid_q <= v2;
                sum_q       <= sum_c;
                cout_q      <= cout_c;
                ovf_q       <= ovf_c;
                acc_op_q    <= b2[PW-1];
            end
            if (retire_c && acc_op_q) begin
                acc_q <= sum_q;
            end
            // At most one accumulator op in flight, so set and clear never coincide.
            if (accept_c && bus.op[1]) begin
                busy_q <= 1'b1;
            end else if (retire_c && acc_op_q) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.acc       = acc_q;
endmodule
